// File: rtl/traffic_light_monitor.sv
// traffic_light_monitor
// Watches the controller's one-hot lights bus (RED=100, GREEN=001, YELLOW=010).
// It checks the encoding, the RED->GREEN->YELLOW->RED order and how long each
// phase lasts. It raises a sticky fault with a cause code, drives a registered
// pedestrian walk signal and counts completed light cycles.
// Optional build macro: TLM_FAULT_AUTOCLEAR_EN. When it is defined, FAULT also
// exits to SYNC after four consecutive RED samples.
module traffic_light_monitor #(
  parameter int MAX_PHASE_CYC = 8,
  parameter int CNT_W         = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [2:0]       lights_in,
  input  logic             clear_fault,
  output logic             walk,
  output logic             fault,
  output logic [1:0]       fault_code,
  output logic [CNT_W-1:0] cycle_count,
  output logic             in_sync
);

  localparam logic [2:0] RED    = 3'b100;
  localparam logic [2:0] GREEN  = 3'b001;
  localparam logic [2:0] YELLOW = 3'b010;

  localparam logic [1:0] CODE_NONE    = 2'b00;
  localparam logic [1:0] CODE_ENCODE  = 2'b01;
  localparam logic [1:0] CODE_ORDER   = 2'b10;
  localparam logic [1:0] CODE_TIMEOUT = 2'b11;

  localparam logic [CNT_W-1:0] MAX_DWELL = CNT_W'(MAX_PHASE_CYC);

  typedef enum logic [2:0] {SYNC, T_RED, T_GREEN, T_YELLOW, FAULT} state_t;

  state_t           state, state_next;
  logic [CNT_W-1:0] dwell, dwell_next;
  logic [1:0]       code_next;
  logic             wrap;
  logic             legal;
  logic [2:0]       cur_light, nxt_light;
  state_t           nxt_state;
`ifdef TLM_FAULT_AUTOCLEAR_EN
  logic [1:0]       red_run;
`endif

  // Current phase's light and the one legally allowed to follow it
  always_comb begin
    cur_light = RED;
    nxt_light = GREEN;
    nxt_state = T_GREEN;
    case (state)
      T_GREEN:  begin cur_light = GREEN;  nxt_light = YELLOW; nxt_state = T_YELLOW; end
      T_YELLOW: begin cur_light = YELLOW; nxt_light = RED;    nxt_state = T_RED;    end
      default:  begin cur_light = RED;    nxt_light = GREEN;  nxt_state = T_GREEN;  end
    endcase
  end

  // Next-state decision for one sample; the checks are ordered so encoding beats order beats timeout
  always_comb begin
    state_next = state;
    dwell_next = dwell;
    code_next  = fault_code;
    wrap       = 1'b0;
    legal      = (lights_in == RED) || (lights_in == GREEN) || (lights_in == YELLOW);
    case (state)
      FAULT: begin
        if (clear_fault) begin
          state_next = SYNC;
          code_next  = CODE_NONE;
          dwell_next = '0;
        end
`ifdef TLM_FAULT_AUTOCLEAR_EN
        else if (lights_in == RED && red_run == 2'd3) begin
          state_next = SYNC;
          code_next  = CODE_NONE;
          dwell_next = '0;
        end
`endif
      end
      default: begin
        if (!legal) begin
          state_next = FAULT;
          code_next  = CODE_ENCODE;
        end else if (state == SYNC) begin
          // Only RED can start tracking; GREEN/YELLOW are skipped until then
          if (lights_in == RED) begin
            state_next = T_RED;
            dwell_next = {{(CNT_W-1){1'b0}}, 1'b1};
          end
        end else if (lights_in == cur_light) begin
          if (dwell == MAX_DWELL) begin
            state_next = FAULT;
            code_next  = CODE_TIMEOUT;
          end else begin
            dwell_next = dwell + 1'b1;
          end
        end else if (lights_in == nxt_light) begin
          state_next = nxt_state;
          dwell_next = {{(CNT_W-1){1'b0}}, 1'b1};
          wrap       = (state == T_YELLOW);
        end else begin
          state_next = FAULT;
          code_next  = CODE_ORDER;
        end
      end
    endcase
  end

  // State, counters and registered outputs; the outputs reflect the state being entered
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= SYNC;
      dwell       <= '0;
      walk        <= 1'b0;
      fault       <= 1'b0;
      fault_code  <= CODE_NONE;
      cycle_count <= '0;
      in_sync     <= 1'b0;
`ifdef TLM_FAULT_AUTOCLEAR_EN
      red_run     <= '0;
`endif
    end else begin
      state      <= state_next;
      dwell      <= dwell_next;
      fault_code <= code_next;
      fault      <= (state_next == FAULT);
      walk       <= (state_next == T_RED);
      in_sync    <= (state_next == T_RED) || (state_next == T_GREEN) || (state_next == T_YELLOW);
      if (wrap)
        cycle_count <= cycle_count + 1'b1;
`ifdef TLM_FAULT_AUTOCLEAR_EN
      // Count consecutive RED samples taken while already in FAULT
      if (state == FAULT && state_next == FAULT && lights_in == RED)
        red_run <= red_run + 1'b1;
      else
        red_run <= '0;
`endif
    end
  end

endmodule

// File: tb/tb_traffic_light_monitor.sv
// Testbench for traffic_light_monitor. A scoreboard queue holds the expected
// outputs for each sample driven, and a monitor compares them one cycle later.
module tb_traffic_light_monitor;

  localparam int MAXP = 8;
  localparam logic [2:0] R = 3'b100;
  localparam logic [2:0] G = 3'b001;
  localparam logic [2:0] Y = 3'b010;

  logic       clk = 1'b0;
  logic       reset;
  logic [2:0] lights_in;
  logic       clear_fault;
  logic       walk, fault, in_sync;
  logic [1:0] fault_code;
  logic [7:0] cycle_count;

  traffic_light_monitor #(.MAX_PHASE_CYC(MAXP), .CNT_W(8)) dut (
    .clk(clk), .reset(reset), .lights_in(lights_in), .clear_fault(clear_fault),
    .walk(walk), .fault(fault), .fault_code(fault_code),
    .cycle_count(cycle_count), .in_sync(in_sync)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       walk;
    logic       fault;
    logic [1:0] code;
    logic [7:0] cnt;
    logic       sync;
  } exp_t;

  exp_t exp_q[$];
  int checks = 0;
  int errors = 0;

  // Reference model: the position in the R,G,Y cycle plus plain counters
  logic [2:0] seq [3];
  bit  m_tracking;
  int  m_phase;
  int  m_run;
  bit  m_faulted;
  int  m_code;
  int  m_cycles;
  int  m_reds;

  task automatic check(input string name, input int act, input int expv);
    checks++;
    if (act != expv) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, expv, $time);
    end
  endtask

  task automatic model_reset();
    m_tracking = 0; m_phase = 0; m_run = 0; m_faulted = 0;
    m_code = 0; m_cycles = 0; m_reds = 0;
  endtask

  task automatic model_fault(input int code);
    m_faulted = 1; m_code = code; m_tracking = 0; m_reds = 0;
  endtask

  task automatic model_unfault();
    m_faulted = 0; m_code = 0; m_tracking = 0; m_run = 0; m_reds = 0;
  endtask

  task automatic model_step(input logic [2:0] l, input logic clr);
    int idx;
    idx = -1;
    for (int k = 0; k < 3; k++) if (seq[k] == l) idx = k;
    if (m_faulted) begin
      if (clr) model_unfault();
      else begin
`ifdef TLM_FAULT_AUTOCLEAR_EN
        if (l == R) m_reds++; else m_reds = 0;
        if (m_reds == 4) model_unfault();
`endif
      end
    end else if (idx < 0) begin
      model_fault(1);
    end else if (!m_tracking) begin
      if (idx == 0) begin m_tracking = 1; m_phase = 0; m_run = 1; end
    end else if (idx == m_phase) begin
      if (m_run == MAXP) model_fault(3); else m_run++;
    end else if (idx == (m_phase + 1) % 3) begin
      if (idx == 0) m_cycles++;
      m_phase = idx; m_run = 1;
    end else begin
      model_fault(2);
    end
  endtask

  function automatic exp_t model_out();
    exp_t e;
    e.walk  = m_tracking && !m_faulted && m_phase == 0;
    e.fault = m_faulted;
    e.code  = 2'(m_code);
    e.cnt   = 8'(m_cycles % 256);
    e.sync  = m_tracking && !m_faulted;
    return e;
  endfunction

  task automatic apply(input logic [2:0] l, input logic clr);
    @(negedge clk);
    lights_in   = l;
    clear_fault = clr;
    model_step(l, clr);
    exp_q.push_back(model_out());
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_walk"}, walk, 0);
    check({tag, "_fault"}, fault, 0);
    check({tag, "_code"}, fault_code, 0);
    check({tag, "_cnt"}, cycle_count, 0);
    check({tag, "_sync"}, in_sync, 0);
  endtask

  // Monitor: one scoreboard entry per sampling edge
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        $display("t=%0t walk=%b fault=%b code=%b cnt=%0d sync=%b", $time, walk, fault, fault_code, cycle_count, in_sync);
        check("walk", walk, e.walk);
        check("fault", fault, e.fault);
        check("fault_code", fault_code, e.code);
        check("cycle_count", cycle_count, e.cnt);
        check("in_sync", in_sync, e.sync);
      end
    end
  end

  // Time limit so the run always ends on its own
  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  // Stimulus
  initial begin
    int g;
    int r;
    logic [2:0] v;
    seq[0] = R; seq[1] = G; seq[2] = Y;
    reset = 1'b1; lights_in = R; clear_fault = 1'b0;
    model_reset();
    #12;
    check_zero("reset");
    @(negedge clk);
    reset = 1'b0;

    // Five clean rounds and a closing RED
    for (int i = 0; i < 5; i++) begin apply(R, 0); apply(G, 0); apply(Y, 0); end
    apply(R, 0);
    // Illegal encoding, ignored lights while faulted, then clear
    apply(3'b110, 0);
    apply(G, 0);
    apply(G, 1);
    // Order violation from RED, clear, GREEN skipped in SYNC, RED resyncs
    apply(R, 0); apply(Y, 0); apply(R, 1);
    apply(G, 0); apply(G, 0); apply(R, 0);
    // Dwell limit: 8 GREEN samples are fine, the 9th faults
    for (int i = 0; i < MAXP + 1; i++) apply(G, 0);
    apply(R, 1);
    // Fault hold across RED runs (auto-exits on the 4th RED when enabled)
    apply(R, 0); apply(3'b000, 0);
    apply(R, 0); apply(R, 0); apply(R, 0); apply(G, 0);
    for (int i = 0; i < 4; i++) apply(R, 0);
    apply(Y, 1);
    // Three rounds, then asynchronous reset in the middle of GREEN
    for (int i = 0; i < 3; i++) begin apply(R, 0); apply(G, 0); apply(Y, 0); end
    apply(R, 0); apply(G, 0);
    @(negedge clk);
    #2;
    reset = 1'b1;
    #1;
    check_zero("async_reset");
    model_reset();
    @(negedge clk);
    reset = 1'b0;
    apply(G, 0); apply(R, 0); apply(G, 0);

    // Randomised traffic with occasional faults and clears
    g = 1;
    for (int i = 0; i < 1500; i++) begin
      r = $urandom_range(0, 99);
      if (r < 62) v = seq[g];
      else if (r < 90) begin g = (g + 1) % 3; v = seq[g]; end
      else if (r < 95) v = 3'($urandom_range(0, 7));
      else begin g = (g + 2) % 3; v = seq[g]; end
      apply(v, ($urandom_range(0, 19) == 0));
    end

    @(negedge clk);
    @(negedge clk);
    check("drain", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
